// File: rtl/ref_clk_qualify_select_pkg.sv
// Shared constants and helpers for the reference-clock qualifier/selector.
// Window defaults match 10 MHz reference measured with 250 MHz clk and a 256-cycle gate.
package ref_clk_qualify_select_pkg;

  localparam int unsigned DEF_GATE_WIDTH        = 8;
  localparam int unsigned DEF_COUNT_WIDTH       = 8;
  localparam int unsigned DEF_LOCK_MIN          = 10;
  localparam int unsigned DEF_LOCK_MAX          = 11;
  localparam int unsigned DEF_HOLD_MIN          = 9;
  localparam int unsigned DEF_HOLD_MAX          = 12;
  localparam int unsigned DEF_VALID_COUNT_WIDTH = 7;
  localparam int unsigned DEF_HOLDOFF_GATES     = 4;
  localparam int unsigned DEF_SYNC_STAGES       = 3;

  // Inclusive window compare on an edge count.
  function automatic logic in_window(input int unsigned c, input int unsigned lo,
                                     input int unsigned hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/ref_clk_qualify_select_meas.sv
// Per-channel frequency measurement: synchroniser, edge counter over the gate window,
// window compare and hysteresis qualification.
module ref_freq_meas
  import ref_clk_qualify_select_pkg::*;
#(
  parameter int unsigned SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter int unsigned COUNT_WIDTH       = DEF_COUNT_WIDTH,
  parameter int unsigned LOCK_MIN          = DEF_LOCK_MIN,
  parameter int unsigned LOCK_MAX          = DEF_LOCK_MAX,
  parameter int unsigned HOLD_MIN          = DEF_HOLD_MIN,
  parameter int unsigned HOLD_MAX          = DEF_HOLD_MAX,
  parameter int unsigned VALID_COUNT_WIDTH = DEF_VALID_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ref_toggle,
  input  logic                   gate,
  output logic                   freq_valid,
  output logic [COUNT_WIDTH-1:0] meas_count
);

  logic [SYNC_STAGES-1:0]       sync_q;
  logic                         cur_q;
  logic                         last_q;
  logic                         edge_det;
  logic [COUNT_WIDTH-1:0]       edge_cnt_q;
  logic [VALID_COUNT_WIDTH-1:0] valid_cnt_q;
  logic                         in_lock;
  logic                         in_hold;

  assign edge_det = cur_q ^ last_q;
  assign in_lock  = in_window(32'(edge_cnt_q), LOCK_MIN, LOCK_MAX);
  assign in_hold  = in_window(32'(edge_cnt_q), HOLD_MIN, HOLD_MAX);

  // Toggle synchroniser and edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cur_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ref_toggle};
      cur_q  <= sync_q[SYNC_STAGES-1];
      last_q <= cur_q;
    end
  end

  // Edge counter; on gate the edge of that same cycle seeds the next window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt_q <= '0;
      meas_count <= '0;
    end else if (gate) begin
      meas_count <= edge_cnt_q;
      edge_cnt_q <= COUNT_WIDTH'(edge_det);
    end else if (edge_det && (edge_cnt_q != '1)) begin
      edge_cnt_q <= edge_cnt_q + COUNT_WIDTH'(1);
    end
  end

  // Hysteresis: acquire inside the inner window, decay outside the outer window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_cnt_q <= '0;
      freq_valid  <= 1'b0;
    end else if (gate) begin
      if (in_lock) begin
        if (valid_cnt_q == '1) freq_valid <= 1'b1;
        else                   valid_cnt_q <= valid_cnt_q + VALID_COUNT_WIDTH'(1);
      end else if (!in_hold) begin
        if (valid_cnt_q != '0) valid_cnt_q <= valid_cnt_q - VALID_COUNT_WIDTH'(1);
        else                   freq_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ref_clk_qualify_select.sv
// N-channel reference-clock qualifier with priority select, upgrade holdoff and
// switch pulse for a BUFGMUX-style clock mux.
module ref_clk_qualify_select
  import ref_clk_qualify_select_pkg::*;
#(
  parameter int unsigned CHANNELS          = 2,
  parameter int unsigned DEFAULT_SEL       = 0,
  parameter int unsigned SEL_WIDTH         = 1,
  parameter int unsigned SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter int unsigned GATE_WIDTH        = DEF_GATE_WIDTH,
  parameter int unsigned COUNT_WIDTH       = DEF_COUNT_WIDTH,
  parameter int unsigned LOCK_MIN          = DEF_LOCK_MIN,
  parameter int unsigned LOCK_MAX          = DEF_LOCK_MAX,
  parameter int unsigned HOLD_MIN          = DEF_HOLD_MIN,
  parameter int unsigned HOLD_MAX          = DEF_HOLD_MAX,
  parameter int unsigned VALID_COUNT_WIDTH = DEF_VALID_COUNT_WIDTH,
  parameter int unsigned HOLDOFF_GATES     = DEF_HOLDOFF_GATES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CHANNELS-1:0]             ref_toggle,
  input  logic [CHANNELS-1:0]             ref_ready,
  output logic [CHANNELS-1:0]             freq_valid,
  output logic [CHANNELS*COUNT_WIDTH-1:0] meas_count,
  output logic [SEL_WIDTH-1:0]            sel,
  output logic                            switch_pulse,
  output logic                            gate
);

  localparam int unsigned HOLDOFF_WIDTH =
    (HOLDOFF_GATES > 0) ? $clog2(HOLDOFF_GATES + 1) : 1;

  logic [GATE_WIDTH-1:0]    gate_cnt_q;
  logic [HOLDOFF_WIDTH-1:0] holdoff_q;
  logic [HOLDOFF_WIDTH-1:0] holdoff_d;
  logic [SEL_WIDTH-1:0]     sel_d;
  logic                     switch_pulse_d;
  logic [CHANNELS-1:0]      elig;
  logic [SEL_WIDTH-1:0]     cand;
  logic                     sel_elig;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_meas
    ref_freq_meas #(
      .SYNC_STAGES      (SYNC_STAGES),
      .COUNT_WIDTH      (COUNT_WIDTH),
      .LOCK_MIN         (LOCK_MIN),
      .LOCK_MAX         (LOCK_MAX),
      .HOLD_MIN         (HOLD_MIN),
      .HOLD_MAX         (HOLD_MAX),
      .VALID_COUNT_WIDTH(VALID_COUNT_WIDTH)
    ) u_meas (
      .clk       (clk),
      .rst       (rst),
      .ref_toggle(ref_toggle[i]),
      .gate      (gate),
      .freq_valid(freq_valid[i]),
      .meas_count(meas_count[i*COUNT_WIDTH +: COUNT_WIDTH])
    );
  end

  // Free-running gate timebase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_cnt_q <= '0;
      gate       <= 1'b0;
    end else begin
      gate_cnt_q <= gate_cnt_q + GATE_WIDTH'(1);
      gate       <= (gate_cnt_q == '0);
    end
  end

  // Eligibility and highest-index candidate; the fallback channel is always eligible
  always_comb begin
    elig              = freq_valid & ref_ready;
    elig[DEFAULT_SEL] = 1'b1;
    cand              = SEL_WIDTH'(DEFAULT_SEL);
    sel_elig          = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (elig[i]) cand = SEL_WIDTH'(i);
      if (sel == SEL_WIDTH'(i)) sel_elig = elig[i];
    end
  end

  // Fault switch bypasses holdoff; upgrades wait for it; a switch reload beats the gate decrement
  always_comb begin
    sel_d          = sel;
    switch_pulse_d = 1'b0;
    holdoff_d      = holdoff_q;
    if (gate && (holdoff_q != '0)) holdoff_d = holdoff_q - HOLDOFF_WIDTH'(1);
    if ((!sel_elig || ((cand > sel) && (holdoff_q == '0))) && (cand != sel)) begin
      sel_d          = cand;
      switch_pulse_d = 1'b1;
      holdoff_d      = HOLDOFF_WIDTH'(HOLDOFF_GATES);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel          <= SEL_WIDTH'(DEFAULT_SEL);
      switch_pulse <= 1'b0;
      holdoff_q    <= '0;
    end else begin
      sel          <= sel_d;
      switch_pulse <= switch_pulse_d;
      holdoff_q    <= holdoff_d;
    end
  end

endmodule

// File: tb/tb_ref_clk_qualify_select.sv
// Bench for ref_clk_qualify_select: 3 channels, short gate and narrow hysteresis counter
// so acquire/loss sequences complete quickly.
`timescale 1ns/100ps
module tb_ref_clk_qualify_select;

  localparam int unsigned CH    = 3;
  localparam int unsigned SW    = 2;
  localparam int unsigned CW    = 8;
  localparam int unsigned GW    = 5;
  localparam int unsigned VCW   = 3;
  localparam int unsigned HOLDG = 4;
  localparam int unsigned ACQ_GATES = (1 << VCW);  // gates from first in-window gate to valid

  logic              clk = 1'b0;
  logic              rst;
  logic [CH-1:0]     ref_toggle;
  logic [CH-1:0]     ref_ready;
  logic [CH-1:0]     freq_valid;
  logic [CH*CW-1:0]  meas_count;
  logic [SW-1:0]     sel;
  logic              switch_pulse;
  logic              gate;

  int checks = 0;
  int errors = 0;
  int unsigned per [CH];
  int unsigned ph  [CH];
  logic [SW-1:0] exp_sel_q [$];

  ref_clk_qualify_select #(
    .CHANNELS(CH), .DEFAULT_SEL(0), .SEL_WIDTH(SW), .SYNC_STAGES(3),
    .GATE_WIDTH(GW), .COUNT_WIDTH(CW), .LOCK_MIN(6), .LOCK_MAX(9),
    .HOLD_MIN(5), .HOLD_MAX(11), .VALID_COUNT_WIDTH(VCW), .HOLDOFF_GATES(HOLDG)
  ) dut (
    .clk(clk), .rst(rst), .ref_toggle(ref_toggle), .ref_ready(ref_ready),
    .freq_valid(freq_valid), .meas_count(meas_count), .sel(sel),
    .switch_pulse(switch_pulse), .gate(gate)
  );

  always #2 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference toggle generators: toggle every per[i] clk cycles, idle when 0
  initial begin
    ref_toggle = '0;
    for (int i = 0; i < CH; i++) begin per[i] = 0; ph[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) begin
        if (per[i] != 0) begin
          ph[i]++;
          if (ph[i] >= per[i]) begin
            ph[i] = 0;
            ref_toggle[i] = ~ref_toggle[i];
          end
        end
      end
    end
  end

  // Scoreboard: every switch pulse must match the next expected selection
  always @(negedge clk) begin
    if (!rst && switch_pulse) begin
      check_val("switch_pending", 32'(exp_sel_q.size() > 0), 1);
      if (exp_sel_q.size() > 0) check_val("switch_sel", 32'(sel), 32'(exp_sel_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_ch(input int ch, input int unsigned p);
    per[ch] = p;
    ph[ch]  = 0;
  endtask

  task automatic wait_gate(input string tag);
    logic found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      tick();
      if (gate) found = 1'b1;
    end
    check_val({tag, "_gate_seen"}, 32'(found), 1);
  endtask

  // Count gates until freq_valid[ch] reaches val
  task automatic watch_fv(input int ch, input logic val, input int max_cyc,
                          output int gates, output logic found);
    gates = 0;
    found = 1'b0;
    for (int c = 0; c < max_cyc && !found; c++) begin
      tick();
      if (freq_valid[ch] === val) found = 1'b1;
      else if (gate) gates++;
    end
  endtask

  int   k;
  int   g;
  int   gap;
  logic found;
  logic sel_stuck;
  logic fv_kept;

  initial begin
    rst       = 1'b1;
    ref_ready = '1;
    repeat (3) tick();
    check_val("rst_sel", 32'(sel), 0);
    check_val("rst_fv", 32'(freq_valid), 0);
    check_val("rst_meas", 32'(meas_count), 0);
    check_val("rst_pulse", 32'(switch_pulse), 0);
    check_val("rst_gate", 32'(gate), 0);
    rst = 1'b0;

    // Gate period
    wait_gate("period_a");
    gap = 0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      tick();
      gap++;
      if (gate) found = 1'b1;
    end
    check_val("gate_period", 32'(gap), 32'(1 << GW));

    // Lock acquire on ch1
    wait_gate("acq");
    exp_sel_q.push_back(SW'(1));
    start_ch(1, 4);
    watch_fv(1, 1'b1, 40 * (1 << GW), k, found);
    check_val("acq_found", 32'(found), 1);
    check_val("acq_gates", 32'(k), ACQ_GATES);
    check_val("acq_sel_before", 32'(sel), 0);
    tick();
    check_val("acq_sel", 32'(sel), 1);
    check_val("acq_pulse", 32'(switch_pulse), 1);
    wait_gate("meas");
    tick();
    check_val("meas_ch1", 32'(meas_count[1*CW +: CW]), 8);
    check_val("meas_ch2", 32'(meas_count[2*CW +: CW]), 0);

    // Ready fault: fall back immediately, return only after the holdoff gates
    repeat (6) wait_gate("holdoff_clear");
    repeat (5) tick();
    exp_sel_q.push_back(SW'(0));
    exp_sel_q.push_back(SW'(1));
    ref_ready[1] = 1'b0;
    tick();
    ref_ready[1] = 1'b1;
    check_val("fault_sel", 32'(sel), 0);
    check_val("fault_pulse", 32'(switch_pulse), 1);
    g = 0;
    sel_stuck = 1'b1;
    for (int c = 0; c < 10 * (1 << GW) && g < int'(HOLDG); c++) begin
      tick();
      if (sel !== SW'(0)) sel_stuck = 1'b0;
      if (gate) g++;
    end
    check_val("holdoff_gates", 32'(g), HOLDG);
    check_val("holdoff_sel_held", 32'(sel_stuck), 1);
    tick();
    check_val("holdoff_last_sel", 32'(sel), 0);
    tick();
    check_val("return_sel", 32'(sel), 1);
    check_val("return_pulse", 32'(switch_pulse), 1);

    // Hysteresis hold: count in outer but not inner window
    start_ch(1, 3);
    g = 0;
    fv_kept = 1'b1;
    for (int c = 0; c < 70 * (1 << GW) && g < 60; c++) begin
      tick();
      if (freq_valid[1] !== 1'b1 || sel !== SW'(1)) fv_kept = 1'b0;
      if (gate) g++;
    end
    check_val("hold_fv_kept", 32'(fv_kept), 1);
    tick();
    check_val("hold_meas_in_hold", 32'(meas_count[1*CW +: CW] >= 10 && meas_count[1*CW +: CW] <= 11), 1);

    // Loss: valid counter must still be saturated, so clearing takes the full count
    wait_gate("loss");
    exp_sel_q.push_back(SW'(0));
    start_ch(1, 0);
    watch_fv(1, 1'b0, 40 * (1 << GW), k, found);
    check_val("loss_found", 32'(found), 1);
    check_val("loss_gates", 32'(k), ACQ_GATES);
    tick();
    check_val("loss_sel", 32'(sel), 0);
    check_val("loss_pulse", 32'(switch_pulse), 1);

    // Priority: ch1 and ch2 qualify on the same gate
    wait_gate("prio");
    exp_sel_q.push_back(SW'(2));
    start_ch(1, 4);
    start_ch(2, 4);
    watch_fv(2, 1'b1, 40 * (1 << GW), k, found);
    check_val("prio_found", 32'(found), 1);
    check_val("prio_gates", 32'(k), ACQ_GATES);
    check_val("prio_fv1_same", 32'(freq_valid[1]), 1);
    tick();
    check_val("prio_sel", 32'(sel), 2);
    check_val("prio_pulse", 32'(switch_pulse), 1);
    repeat (100) tick();
    check_val("prio_sel_stable", 32'(sel), 2);

    // Asynchronous reset mid-operation
    repeat ($urandom_range(40, 300)) tick();
    #0.5;
    rst = 1'b1;
    #0.5;
    check_val("arst_sel", 32'(sel), 0);
    check_val("arst_fv", 32'(freq_valid), 0);
    check_val("arst_meas", 32'(meas_count), 0);
    check_val("arst_pulse", 32'(switch_pulse), 0);
    check_val("arst_gate", 32'(gate), 0);
    repeat (3) tick();
    exp_sel_q.push_back(SW'(2));
    rst = 1'b0;
    tick();
    check_val("post_rst_sel", 32'(sel), 0);
    check_val("post_rst_pulse", 32'(switch_pulse), 0);
    watch_fv(2, 1'b1, 40 * (1 << GW), k, found);
    check_val("relock_found", 32'(found), 1);
    repeat (3) tick();
    check_val("relock_sel", 32'(sel), 2);

    check_val("switch_queue_drained", 32'(exp_sel_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
